// File: rtl/keypad_bcd_entry_pkg.sv
// Shared definitions for the keypad BCD entry block: FSM encoding and key/counter widths.
package keypad_bcd_entry_pkg;

  localparam int NUM_KEYS   = 10;
  localparam int KEY_CODE_W = 4;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kp_state_e;

endpackage

// File: rtl/keypad_bcd_entry_enc.sv
// Priority encoder for the ten keypad lines: the highest asserted key index wins.
module key_priority_enc
  import keypad_bcd_entry_pkg::*;
(
  input  logic [NUM_KEYS-1:0]   dec_i,
  output logic [KEY_CODE_W-1:0] code_o,
  output logic                  valid_o
);

  // Highest-index-wins code selection
  always_comb begin
    code_o  = 4'd0;
    valid_o = |dec_i;
    casez (dec_i)
      10'b1?????????: code_o = 4'd9;
      10'b01????????: code_o = 4'd8;
      10'b001???????: code_o = 4'd7;
      10'b0001??????: code_o = 4'd6;
      10'b00001?????: code_o = 4'd5;
      10'b000001????: code_o = 4'd4;
      10'b0000001???: code_o = 4'd3;
      10'b00000001??: code_o = 4'd2;
      10'b000000001?: code_o = 4'd1;
      10'b0000000001: code_o = 4'd0;
      default:        code_o = 4'd0;
    endcase
  end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Debounced 0-9 keypad front end that shifts each accepted key into a BCD entry register.
module keypad_bcd_entry
  import keypad_bcd_entry_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OVERFLOW_SHIFT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              DEC,
  input  logic                    EN_N,
  input  logic                    CLR,
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic [3:0]              COUNT,
  output logic                    FULL,
  output logic                    LOAD_N
);

  localparam int               DW          = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [3:0]       NUM_DIG_C   = 4'(NUM_DIGITS);
  localparam logic             OVF_SHIFT_C = (OVERFLOW_SHIFT != 0);

  logic [NUM_KEYS-1:0]   dec_meta_q, dec_sync_q;
  logic [KEY_CODE_W-1:0] key_code_s;
  logic                  key_vld_s;
  logic [1:0]            prime_q;
  logic                  armed_q, armed_d;
  kp_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [KEY_CODE_W-1:0] key_q, key_d;
  logic                  accept_s;
  logic [DW-1:0]         digits_q, digits_d;
  logic [3:0]            count_q, count_d;
  logic                  full_q;
  logic                  load_n_q, load_s;

  key_priority_enc u_enc (
    .dec_i   (dec_sync_q),
    .code_o  (key_code_s),
    .valid_o (key_vld_s)
  );

  // A key held through reset must be seen released before it can be accepted;
  // prime_q delays that judgement until the synchroniser holds post-reset samples.
  assign armed_d = armed_q | (prime_q[1] & ~key_vld_s);

  // Synchroniser, post-reset priming and release-arming flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_meta_q <= 10'd0;
      dec_sync_q <= 10'd0;
      prime_q    <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      dec_meta_q <= DEC;
      dec_sync_q <= dec_meta_q;
      prime_q    <= {prime_q[0], 1'b1};
      armed_q    <= armed_d;
    end
  end

  // Debounce FSM state, sample counter and captured key code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      key_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  // Debounce next-state logic; accept_s marks the single accept edge of a press
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    accept_s = 1'b0;
    if (EN_N) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_vld_s && armed_q) begin
            key_d = key_code_s;
            cnt_d = 8'd1;
            if (DEB_LAST == 8'd1) begin
              state_d  = ST_HELD;
              accept_s = 1'b1;
            end else begin
              state_d = ST_PRESS_WAIT;
            end
          end else begin
            cnt_d = 8'd0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!key_vld_s) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end else if (key_code_s != key_q) begin
            key_d = key_code_s;
            cnt_d = 8'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == DEB_LAST) begin
              state_d  = ST_HELD;
              accept_s = 1'b1;
            end else begin
              state_d = ST_PRESS_WAIT;
            end
          end
        end
        ST_HELD: begin
          if (!key_vld_s) begin
            cnt_d   = 8'd1;
            state_d = (DEB_LAST == 8'd1) ? ST_IDLE : ST_RELEASE_WAIT;
          end else begin
            state_d = ST_HELD;
          end
        end
        ST_RELEASE_WAIT: begin
          if (key_vld_s) begin
            state_d = ST_HELD;
          end else if (cnt_q + 8'd1 == DEB_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Entry register update: clear has priority over an accepted key
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    load_s   = 1'b0;
    if (CLR) begin
      digits_d = '0;
      count_d  = 4'd0;
    end else if (accept_s) begin
      if (count_q < NUM_DIG_C) begin
        digits_d = (digits_q << 3'd4) | DW'(key_code_s);
        count_d  = count_q + 4'd1;
        load_s   = 1'b1;
      end else if (OVF_SHIFT_C) begin
        digits_d = (digits_q << 3'd4) | DW'(key_code_s);
        load_s   = 1'b1;
      end else begin
        digits_d = digits_q;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Registered entry value, digit count, full flag and load strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      count_q  <= 4'd0;
      full_q   <= 1'b0;
      load_n_q <= 1'b1;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      full_q   <= (count_d == NUM_DIG_C);
      load_n_q <= ~load_s;
    end
  end

  assign DIGITS = digits_q;
  assign COUNT  = count_q;
  assign FULL   = full_q;
  assign LOAD_N = load_n_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Randomised and directed bench for keypad_bcd_entry against a queue-based entry model.
module tb_keypad_bcd_entry;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  dec;
  logic        en_n;
  logic        clr;
  logic [15:0] digits1, digits0;
  logic [3:0]  count1, count0;
  logic        full1, full0, load_n1, load_n0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses1 = 0, pulses0 = 0, dbl1 = 0, dbl0 = 0, last_load_cyc = -1;
  int exp_p1 = 0, exp_p0 = 0;
  logic prev1 = 1'b1, prev0 = 1'b1;
  int q1[$];
  int q0[$];

  keypad_bcd_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(DEB), .OVERFLOW_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .DEC(dec), .EN_N(en_n), .CLR(clr),
    .DIGITS(digits1), .COUNT(count1), .FULL(full1), .LOAD_N(load_n1)
  );

  keypad_bcd_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(DEB), .OVERFLOW_SHIFT(0)) dut_ns (
    .clk(clk), .rst(rst), .DEC(dec), .EN_N(en_n), .CLR(clr),
    .DIGITS(digits0), .COUNT(count0), .FULL(full0), .LOAD_N(load_n0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!load_n1) begin
      pulses1++;
      last_load_cyc = cyc;
      if (!prev1) dbl1++;
    end
    if (!load_n0) begin
      pulses0++;
      if (!prev0) dbl0++;
    end
    prev1 = load_n1;
    prev0 = load_n0;
  end

  // Entry model: a list of digits, oldest first; size is the digit count.
  function automatic void model_accept(input int k);
    if (q1.size() < 4) q1.push_back(k);
    else begin
      void'(q1.pop_front());
      q1.push_back(k);
    end
    exp_p1++;
    if (q0.size() < 4) begin
      q0.push_back(k);
      exp_p0++;
    end
  endfunction

  function automatic logic [15:0] model_val(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return 16'(v);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int k, input int hold, input int rel, input bit noise);
    logic [9:0] v;
    v = 10'd1 << k;
    if (noise) v = v | (10'($urandom) & (v - 10'd1));
    dec = v;
    step(hold);
    dec = 10'd0;
    step(rel);
    if (hold >= DEB) model_accept(k);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    q1.delete();
    q0.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; dec = 10'd0; en_n = 1'b0; clr = 1'b0;
    #3;
    checks++; if (digits1 !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h want 0000", digits1); end
    checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count1); end
    checks++; if (full1 !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full1); end
    checks++; if (load_n1 !== 1'b1) begin errors++; $display("FAIL reset_load_n: got %b want 1", load_n1); end
    step(3);
    rst = 1'b0;
    step(5);
  endtask

  task automatic test_basic_sequence();
    press(1, 10, 10, 1'b0);
    press(2, 10, 10, 1'b0);
    press(3, 10, 10, 1'b0);
    checks++; if (digits1 !== 16'h0123) begin errors++; $display("FAIL basic_digits: got %h want 0123", digits1); end
    checks++; if (count1 !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", count1); end
    checks++; if (pulses1 !== 3) begin errors++; $display("FAIL basic_pulses: got %0d want 3", pulses1); end
    checks++; if (dbl1 !== 0) begin errors++; $display("FAIL basic_pulse_width: got %0d long pulses want 0", dbl1); end
    checks++; if (full1 !== 1'b0) begin errors++; $display("FAIL basic_full: got %b want 0", full1); end
  endtask

  task automatic test_latency();
    int c0;
    dec = 10'd1 << 4;
    c0 = cyc;
    step(10);
    dec = 10'd0;
    step(10);
    model_accept(4);
    checks++; if (last_load_cyc !== c0 + 2 + DEB) begin errors++; $display("FAIL latency: got strobe after edge %0d want %0d", last_load_cyc - c0, 2 + DEB); end
    checks++; if (digits1 !== model_val(q1)) begin errors++; $display("FAIL latency_digits: got %h want %h", digits1, model_val(q1)); end
    checks++; if (full1 !== 1'b1) begin errors++; $display("FAIL latency_full: got %b want 1", full1); end
  endtask

  task automatic test_overflow();
    press(5, 10, 10, 1'b0);
    checks++; if (digits1 !== 16'h2345) begin errors++; $display("FAIL ovf_shift_digits: got %h want 2345", digits1); end
    checks++; if (count1 !== 4'd4) begin errors++; $display("FAIL ovf_shift_count: got %0d want 4", count1); end
    checks++; if (full1 !== 1'b1) begin errors++; $display("FAIL ovf_shift_full: got %b want 1", full1); end
    checks++; if (digits0 !== 16'h1234) begin errors++; $display("FAIL ovf_hold_digits: got %h want 1234", digits0); end
    checks++; if (pulses0 !== 4) begin errors++; $display("FAIL ovf_hold_pulses: got %0d want 4", pulses0); end
    checks++; if (pulses1 !== 5) begin errors++; $display("FAIL ovf_shift_pulses: got %0d want 5", pulses1); end
  endtask

  task automatic test_bounce();
    press(7, 3, 10, 1'b0);
    dec = 10'd1 << 7; step(1);
    dec = 10'd0;      step(1);
    dec = 10'd1 << 7; step(1);
    dec = 10'd0;      step(10);
    checks++; if (digits1 !== model_val(q1)) begin errors++; $display("FAIL bounce_digits: got %h want %h", digits1, model_val(q1)); end
    checks++; if (pulses1 !== exp_p1) begin errors++; $display("FAIL bounce_pulses: got %0d want %0d", pulses1, exp_p1); end
  endtask

  task automatic test_priority();
    do_clear();
    step(1);
    checks++; if (digits1 !== 16'h0000 || count1 !== 4'd0) begin errors++; $display("FAIL clear: got %h/%0d want 0000/0", digits1, count1); end
    dec = 10'b1000000100;
    step(20);
    dec = 10'd0;
    step(10);
    model_accept(9);
    checks++; if (digits1 !== 16'h0009) begin errors++; $display("FAIL priority_digits: got %h want 0009", digits1); end
    checks++; if (pulses1 !== exp_p1) begin errors++; $display("FAIL priority_pulses: got %0d want %0d", pulses1, exp_p1); end
  endtask

  task automatic test_clr_on_accept();
    dec = 10'd1 << 5;
    step(5);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    q1.delete();
    q0.delete();
    step(8);
    dec = 10'd0;
    step(10);
    checks++; if (digits1 !== 16'h0000) begin errors++; $display("FAIL clr_accept_digits: got %h want 0000", digits1); end
    checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL clr_accept_count: got %0d want 0", count1); end
    checks++; if (pulses1 !== exp_p1) begin errors++; $display("FAIL clr_accept_pulses: got %0d want %0d", pulses1, exp_p1); end
  endtask

  task automatic test_enable();
    press(8, 10, 10, 1'b0);
    en_n = 1'b1;
    dec = 10'd1 << 3;
    step(20);
    dec = 10'd0;
    step(10);
    en_n = 1'b0;
    step(2);
    checks++; if (digits1 !== model_val(q1)) begin errors++; $display("FAIL enable_digits: got %h want %h", digits1, model_val(q1)); end
    checks++; if (pulses1 !== exp_p1) begin errors++; $display("FAIL enable_pulses: got %0d want %0d", pulses1, exp_p1); end
  endtask

  task automatic test_random();
    int k, hold, rel;
    for (int n = 0; n < 30; n++) begin
      k    = $urandom_range(0, 9);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB - 1) : $urandom_range(DEB, 12);
      rel  = $urandom_range(DEB + 1, 9);
      press(k, hold, rel, 1'($urandom_range(0, 1)));
      checks++; if (digits1 !== model_val(q1)) begin errors++; $display("FAIL rand_digits[%0d]: got %h want %h", n, digits1, model_val(q1)); end
      checks++; if (digits0 !== model_val(q0)) begin errors++; $display("FAIL rand_digits_ns[%0d]: got %h want %h", n, digits0, model_val(q0)); end
      checks++; if (count1 !== 4'(q1.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, count1, q1.size()); end
    end
    checks++; if (pulses1 !== exp_p1) begin errors++; $display("FAIL rand_pulses: got %0d want %0d", pulses1, exp_p1); end
    checks++; if (pulses0 !== exp_p0) begin errors++; $display("FAIL rand_pulses_ns: got %0d want %0d", pulses0, exp_p0); end
    checks++; if (dbl1 !== 0 || dbl0 !== 0) begin errors++; $display("FAIL rand_pulse_width: got %0d/%0d long pulses want 0", dbl1, dbl0); end
  endtask

  task automatic test_reset_mid_press();
    dec = 10'd1 << 6;
    step(3);
    rst = 1'b1;
    q1.delete();
    q0.delete();
    #2;
    checks++; if (digits1 !== 16'h0000 || count1 !== 4'd0) begin errors++; $display("FAIL midrst_async: got %h/%0d want 0000/0", digits1, count1); end
    checks++; if (load_n1 !== 1'b1 || full1 !== 1'b0) begin errors++; $display("FAIL midrst_flags: got load_n=%b full=%b want 1/0", load_n1, full1); end
    step(2);
    rst = 1'b0;
    step(15);
    checks++; if (pulses1 !== exp_p1) begin errors++; $display("FAIL midrst_no_accept: got %0d want %0d", pulses1, exp_p1); end
    checks++; if (digits1 !== 16'h0000) begin errors++; $display("FAIL midrst_digits: got %h want 0000", digits1); end
    dec = 10'd0;
    step(10);
    press(6, 10, 10, 1'b0);
    checks++; if (digits1 !== 16'h0006) begin errors++; $display("FAIL midrst_repress: got %h want 0006", digits1); end
    checks++; if (pulses1 !== exp_p1) begin errors++; $display("FAIL midrst_repress_pulses: got %0d want %0d", pulses1, exp_p1); end
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_latency();
    test_overflow();
    test_bounce();
    test_priority();
    test_clr_on_accept();
    test_enable();
    test_random();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
